// File: rtl/solver_dispatch.sv
// Host front end for one fractal solver: takes a job header plus c limbs,
// drives the solver load/start protocol and hands back the iteration count.
module solver_dispatch #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_BITS       = 32,
  parameter int ID_BITS         = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [LIMB_INDEX_BITS-1:0] job_num_limbs,
  input  logic [15:0]                job_iter_lim,
  input  logic [ID_BITS-1:0]         job_id,
  input  logic                       limb_valid,
  output logic                       limb_ready,
  input  logic [LIMB_BITS-1:0]       limb_data,
  output logic                       wr_real_en,
  output logic                       wr_imag_en,
  output logic [LIMB_INDEX_BITS-1:0] wr_ind,
  output logic [LIMB_BITS-1:0]       c_wr_data,
  output logic                       wr_num_limbs_en,
  output logic                       wr_iter_lim_en,
  output logic [LIMB_INDEX_BITS-1:0] num_limbs_data,
  output logic [15:0]                iter_lim_data,
  output logic                       start,
  input  logic                       out_ready,
  input  logic [15:0]                iteration_count,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [15:0]                res_count,
  output logic                       res_escaped,
  output logic                       res_err,
  output logic [ID_BITS-1:0]         res_id
);

  typedef enum logic [3:0] {
    IDLE, HDR, LOAD_RE, LOAD_IM, LAST, START, ARM, WAIT_DONE, RESULT
  } state_t;

  typedef struct packed {
    logic [LIMB_INDEX_BITS-1:0] num_limbs;
    logic [ID_BITS-1:0]         id;
  } job_t;

  localparam logic [LIMB_INDEX_BITS-1:0] NL_MAX = '1;

  state_t                     state;
  job_t                       job_q;
  logic [LIMB_INDEX_BITS-1:0] k;
  logic                       last_beat;

  assign last_beat = (k == job_q.num_limbs - LIMB_INDEX_BITS'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      job_q           <= '0;
      k               <= '0;
      job_ready       <= 1'b0;
      limb_ready      <= 1'b0;
      wr_real_en      <= 1'b0;
      wr_imag_en      <= 1'b0;
      wr_ind          <= '0;
      c_wr_data       <= '0;
      wr_num_limbs_en <= 1'b0;
      wr_iter_lim_en  <= 1'b0;
      num_limbs_data  <= '0;
      iter_lim_data   <= '0;
      start           <= 1'b0;
      res_valid       <= 1'b0;
      res_count       <= '0;
      res_escaped     <= 1'b0;
      res_err         <= 1'b0;
      res_id          <= '0;
    end else begin
      // single-cycle strobes fall back to 0 unless re-armed below
      wr_real_en      <= 1'b0;
      wr_imag_en      <= 1'b0;
      wr_num_limbs_en <= 1'b0;
      wr_iter_lim_en  <= 1'b0;
      start           <= 1'b0;
      case (state)
        IDLE: begin
          job_ready <= 1'b1;
          if (job_valid && job_ready) begin
            job_ready       <= 1'b0;
            job_q.num_limbs <= job_num_limbs;
            job_q.id        <= job_id;
            if (job_num_limbs == '0 || job_num_limbs == NL_MAX) begin
              res_valid   <= 1'b1;
              res_err     <= 1'b1;
              res_count   <= '0;
              res_escaped <= 1'b0;
              res_id      <= job_id;
              state       <= RESULT;
            end else begin
              res_err         <= 1'b0;
              wr_num_limbs_en <= 1'b1;
              wr_iter_lim_en  <= 1'b1;
              num_limbs_data  <= job_num_limbs;
              iter_lim_data   <= job_iter_lim;
              state           <= HDR;
            end
          end
        end
        HDR: begin
          k          <= '0;
          limb_ready <= 1'b1;
          state      <= LOAD_RE;
        end
        LOAD_RE, LOAD_IM: begin
          // limb_ready is held high throughout both load states
          if (limb_valid) begin
            wr_real_en <= (state == LOAD_RE);
            wr_imag_en <= (state == LOAD_IM);
            wr_ind     <= k;
            c_wr_data  <= limb_data;
            if (last_beat) begin
              k <= '0;
              if (state == LOAD_IM) begin
                limb_ready <= 1'b0;
                state      <= LAST;
              end else begin
                state <= LOAD_IM;
              end
            end else begin
              k <= k + LIMB_INDEX_BITS'(1);
            end
          end
        end
        LAST: begin
          start <= 1'b1;
          state <= START;
        end
        START: state <= ARM;
        // out_ready may still be high from the previous job here
        ARM: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (out_ready) begin
            res_valid   <= 1'b1;
            res_count   <= iteration_count;
            res_escaped <= (iteration_count != 16'hFFFF);
            res_id      <= job_q.id;
            state       <= RESULT;
          end
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            job_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/solver_dispatch.md
# solver_dispatch

Host-side front end for one fractal solver core. Accepts a job (limb count, iteration limit, tag) plus a stream of c limbs. Programs the solver through its load interface (limb-write strobes, num-limbs / iteration-limit writes, start), then waits for the solver's done flag. Returns the captured iteration count on a valid/ready result port, so the solver's LOAD-phase protocol never leaks to the host.

## Interface
Parameters:
- LIMB_INDEX_BITS, 6, width of limb index and limb count
- LIMB_BITS, 32, width of one c limb
- ID_BITS, 8, width of job tag

Ports:
- clock  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- job_valid  in  1  job header present
- job_ready  out  1  header accepted when job_valid && job_ready
- job_num_limbs  in  LIMB_INDEX_BITS  limbs per component
- job_iter_lim  in  16  iteration limit
- job_id  in  ID_BITS  tag, returned with result
- limb_valid  in  1  limb beat present
- limb_ready  out  1  beat accepted when limb_valid && limb_ready
- limb_data  in  LIMB_BITS  limb value; order: real idx 0..n-1, then imag idx 0..n-1
- wr_real_en  out  1  write c real limb
- wr_imag_en  out  1  write c imag limb
- wr_ind  out  LIMB_INDEX_BITS  limb index for the write
- c_wr_data  out  LIMB_BITS  limb value for the write
- wr_num_limbs_en, wr_iter_lim_en  out  1 each  parameter write strobes
- num_limbs_data  out  LIMB_INDEX_BITS
- iter_lim_data  out  16
- start  out  1  one-cycle solve start
- out_ready  in  1  solver done; level, stays high until next start
- iteration_count  in  16  solver result; 16'hFFFF = limit reached
- res_valid  out  1  result held
- res_ready  in  1  result consumed when res_valid && res_ready
- res_count  out  16
- res_escaped  out  1  res_count != 16'hFFFF
- res_err  out  1  job rejected
- res_id  out  ID_BITS

## Operation
- States: IDLE, HDR, LOAD_RE, LOAD_IM, LAST, START, ARM, WAIT_DONE, RESULT.
- IDLE:
  - job_ready=1.
  - On handshake, capture the header.
  - If num_limbs is 0 or all-ones: go to RESULT with res_err=1, res_count=0, res_escaped=0, and no solver activity.
  - Otherwise go to HDR.
- HDR: wr_num_limbs_en=wr_iter_lim_en=1 for one cycle, with captured values; limb counter k=0; go to LOAD_RE.
- LOAD_RE / LOAD_IM:
  - limb_ready=1.
  - Each handshake registers one write: the next cycle shows wr_real_en (or wr_imag_en)=1, wr_ind=k, c_wr_data=beat. Then k increments.
  - After beat n-1: LOAD_RE goes to LOAD_IM with k=0; LOAD_IM goes to LAST.
  - A gap on limb_valid stalls the state with no strobe.
- LAST: final imag strobe visible; go to START.
- START: start=1 for one cycle; go to ARM.
- ARM: out_ready ignored, because it may still be high from the previous job. Go to WAIT_DONE.
- WAIT_DONE: when out_ready=1, capture iteration_count, res_id and res_escaped; go to RESULT.
- RESULT: res_valid=1 with stable fields until handshake, then IDLE.
- At most one job in flight. job_ready=0 and limb_ready=0 outside the states above.

## Timing
- Reset values:
  - state IDLE.
  - All strobes, start, limb_ready and res_valid are 0.
  - All data outputs are 0.
  - job_ready is 1 from the first edge after reset_n rises.
- Assertion of reset_n low in any state aborts immediately to IDLE, discards the job and clears outputs. The solver is reset by its own reset.
- Header accepted at T:
  - HDR strobes at T+1.
  - With continuous limbs: real strobes T+3..T+n+2, imag strobes T+n+3..T+2n+2, start at T+2n+3.
- Result: res_valid rises the cycle after out_ready is sampled high in WAIT_DONE.
- Error job: res_valid at T+1.
- Strobe outputs are registered or decoded only from state registers; no input-to-output combinational paths.

## Test plan
- Reset, then release: all outputs 0, job_ready=1; reset_n low mid-LOAD_IM returns to IDLE with no further strobes.
- n=2, lim=100, limbs A,B,C,D continuous, header at T:
  - HDR at T+1.
  - wr_real_en ind0/A at T+3, ind1/B at T+4.
  - wr_imag_en ind0/C at T+5, ind1/D at T+6.
  - start at T+7.
  - Solver model returns 37 → res_count=37, res_escaped=1, res_id matches.
- limb_valid toggling 1,0,1,0: strobes appear only after accepted beats, and indices stay contiguous.
- Solver returns 16'hFFFF → res_escaped=0. A back-to-back job with stale out_ready=1 during ARM must not complete early.
- num_limbs=0 and num_limbs=63 → no strobes, no start; res_err=1 at T+1.
- res_ready low for 10 cycles → res_* stable and job_ready=0; a job is accepted only after the handshake.
